// File: rtl/pio_link_pkg.sv
// pio_link_pkg: shared opcodes, FSM states, field widths and pio_in bit map for the PIO command link
package pio_link_pkg;
  localparam int OP_W = 3;
  localparam int ARG_W = 12;
  localparam int RSP_W = 8;
  localparam int CMD_W = OP_W + ARG_W;
  localparam logic [OP_W-1:0] OP_CLR = 3'b111;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;
  localparam int ACK_B = 15;
  localparam int FULL_B = 14;
  localparam int BUSY_B = 13;
  localparam int OVF_B = 12;
  localparam int TMO_B = 11;
  localparam int LVL_MSB = 10;
  localparam int LVL_LSB = 8;
  localparam int RSP_MSB = 7;
  localparam int RSP_LSB = 0;
endpackage

// File: rtl/pio_link_fifo.sv
// pio_link_fifo: synchronous command FIFO, power-of-2 depth, push+pop allowed when full
module pio_link_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/pio_cmd_link_ctrl.sv
// pio_cmd_link_ctrl: PIO toggle-detected command queue, valid/ready issue and response status word.
// Optional response timeout with `define RESP_TIMEOUT_EN.
module pio_cmd_link_ctrl
  import pio_link_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter logic [RSP_W-1:0] TMO_RSP = 8'hFF
) (
  input  logic clk,
  input  logic reset,
  input  logic [15:0] pio_out,
  output logic [15:0] pio_in,
  output logic cmd_valid,
  output logic [OP_W-1:0] cmd_op,
  output logic [ARG_W-1:0] cmd_arg,
  input  logic cmd_ready,
  input  logic rsp_valid,
  input  logic [RSP_W-1:0] rsp_data
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  state_t state_q, state_d;
  logic tog_q, ovf_q, tmo_q, tmo_hit, full, empty, push, pop, rsp_take, edge_det, is_clr, busy;
  logic [RSP_W-1:0] last_rsp_q;
  logic [LW-1:0] level;
  logic [CMD_W-1:0] head;
  logic [2:0] lvl_f;
  logic [15:0] pio_d;
  assign edge_det = pio_out[15] != tog_q;
  assign is_clr = edge_det && pio_out[14:12] == OP_CLR;
  // a full FIFO still accepts a word when the head leaves in the same cycle
  assign push = edge_det && !is_clr && (!full || pop);
  assign cmd_valid = state_q == ISSUE;
  assign {cmd_op, cmd_arg} = head;
  assign busy = state_q != IDLE || level != '0;
  assign lvl_f = 32'(level) > 7 ? 3'd7 : 3'(level);
  pio_link_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(pio_out[CMD_W-1:0]),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  always_comb begin
    pop = state_q == ISSUE && cmd_ready;
    rsp_take = state_q == WAIT_RSP && rsp_valid;
    state_d = state_q == IDLE  ? (empty ? IDLE : ISSUE) :
              state_q == ISSUE ? (cmd_ready ? WAIT_RSP : ISSUE) :
              (rsp_valid || tmo_hit) ? IDLE : WAIT_RSP;
  end
  always_comb begin
    pio_d = '0;
    pio_d[ACK_B] = tog_q;
    pio_d[FULL_B] = full;
    pio_d[BUSY_B] = busy;
    pio_d[OVF_B] = ovf_q;
    pio_d[TMO_B] = tmo_q;
    pio_d[LVL_MSB:LVL_LSB] = lvl_f;
    pio_d[RSP_MSB:RSP_LSB] = last_rsp_q;
  end
  // tog_q tracks pio_out[15] even in reset so releasing reset never looks like a new word
  always_ff @(posedge clk)
    if (reset) begin
      tog_q <= pio_out[15];
      state_q <= IDLE;
      ovf_q <= 1'b0;
      last_rsp_q <= '0;
      pio_in <= {pio_out[15], 15'b0};
    end else begin
      tog_q <= pio_out[15];
      state_q <= state_d;
      ovf_q <= is_clr ? 1'b0 : ovf_q | (edge_det && !push);
      last_rsp_q <= rsp_take ? rsp_data : tmo_hit ? TMO_RSP : last_rsp_q;
      pio_in <= pio_d;
    end
`ifdef RESP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] cnt_q;
  assign tmo_hit = state_q == WAIT_RSP && !rsp_valid && cnt_q == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= state_q == WAIT_RSP ? cnt_q + 1'b1 : '0;
      tmo_q <= (tmo_q && !is_clr) || tmo_hit;
    end
`else
  logic unused_tmo;
  assign unused_tmo = ^{TMO_RSP, 32'(TIMEOUT_CYC)};
  assign tmo_hit = 1'b0;
  assign tmo_q = 1'b0;
`endif
endmodule

// File: tb/tb_pio_cmd_link_ctrl.sv
// tb_pio_cmd_link_ctrl: scoreboard bench for the PIO command link, default or RESP_TIMEOUT_EN build
module tb_pio_cmd_link_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] pio_out = '0;
  logic [15:0] pio_in;
  logic cmd_valid, cmd_ready = 1'b0, rsp_valid = 1'b0;
  logic [2:0] cmd_op;
  logic [11:0] cmd_arg;
  logic [7:0] rsp_data = '0;
  int checks = 0, errors = 0;
  logic [14:0] exp_q[$];
  always #5 clk = ~clk;
  pio_cmd_link_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYC(16), .TMO_RSP(8'hFF)) dut (
    .clk(clk),
    .reset(reset),
    .pio_out(pio_out),
    .pio_in(pio_in),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_arg(cmd_arg),
    .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic word(input logic [15:0] w, input bit issued);
    pio_out = w;
    if (issued) exp_q.push_back(w[14:0]);
  endtask
  task automatic do_reset(input logic [15:0] w);
    reset = 1'b1;
    pio_out = w;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    cyc(2);
    reset = 1'b0;
    exp_q.delete();
    cyc();
  endtask
  // every accepted handshake must match the oldest expected command
  always @(negedge clk)
    if (!reset && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) check("cmd_unexpected", {17'b0, cmd_op, cmd_arg}, 32'hFFFF_FFFF);
      else check("cmd", {17'b0, cmd_op, cmd_arg}, {17'b0, exp_q.pop_front()});
    end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    do_reset(16'h8000);
    check("rst_pio", pio_in, 16'h8000);
    check("rst_valid", cmd_valid, 0);
    cyc(4);
    check("rst_idle_pio", pio_in, 16'h8000);
    check("rst_idle_valid", cmd_valid, 0);
    do_reset(16'h0000);
    check("rst0_pio", pio_in, 16'h0000);
    cmd_ready = 1'b1;
    word(16'h9123, 1);
    check("lat_n", cmd_valid, 0);
    cyc();
    check("lat_n1", cmd_valid, 0);
    cyc();
    check("lat_n2", cmd_valid, 1);
    cyc();
    rsp_valid = 1'b1;
    rsp_data = 8'h5A;
    cyc();
    rsp_valid = 1'b0;
    cyc();
    check("rsp_5a", pio_in, 16'h805A);
    cmd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      logic tg;
      tg = (i % 2) == 0;
      word({tg, 3'd2, 12'(i)}, i < 5);
      cyc(2);
      check("ack_track", pio_in[15], tg);
    end
    check("overflow", pio_in, 16'h745A);
    check("ovf_valid", cmd_valid, 1);
    word(16'hF000, 0);
    cyc(2);
    check("clr", pio_in, 16'hE45A);
    check("clr_valid", cmd_valid, 1);
    cmd_ready = 1'b1;
    word(16'h3ABC, 1);
    cyc(2);
    check("full_pushpop", pio_in, 16'h645A);
    rsp_data = 8'h3C;
    rsp_valid = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) cyc();
    check("drain_left", exp_q.size(), 0);
    cyc(5);
    rsp_valid = 1'b0;
    cyc(2);
    check("drained", pio_in, 16'h003C);
    word(16'hC055, 1);
    cyc(19);
`ifdef RESP_TIMEOUT_EN
    check("tmo_busy", pio_in[13], 1);
    cyc();
    check("tmo", pio_in, 16'h88FF);
`else
    cyc(100);
    check("no_tmo", pio_in, 16'hA03C);
`endif
    do_reset(16'hC055);
    check("mid_rst", pio_in, 16'h8000);
    rsp_valid = 1'b1;
    rsp_data = 8'h77;
    cyc();
    rsp_valid = 1'b0;
    cyc(2);
    check("late_rsp", pio_in, 16'h8000);
    check("late_valid", cmd_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
